// File: rtl/uart_rx.sv
// Serial receiver: 2-flop synchronised rx, start/data/stop framing sampled mid-bit, break hold-off.
// Latency: pulse one cycle after the stop sample; no backpressure, consumer captures rx_data on rx_valid.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [15:0] BIT_END      = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END     = 16'(HALF_BIT - 1);
    localparam logic [2:0]  LAST_BIT     = 3'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_baud
            $error("uart_rx: CLK_FREQ/BAUD_RATE must give 4..65535 clocks per bit");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
            $error("uart_rx: DATA_BITS must be 5..8");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   rx_meta;
    logic                   rx_s;
    logic [15:0]            clk_count;
    logic [15:0]            count_nxt;
    logic [2:0]             bit_index;
    logic [2:0]             index_nxt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_nxt;
    logic [DATA_BITS-1:0]   data_nxt;
    logic                   valid_nxt;
    logic                   err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            clk_count <= '0;
            bit_index <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            state     <= state_nxt;
            clk_count <= count_nxt;
            bit_index <= index_nxt;
            shift_reg <= shift_nxt;
            rx_data   <= data_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = clk_count;
        index_nxt = bit_index;
        shift_nxt = shift_reg;
        data_nxt  = rx_data;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                count_nxt = '0;
                index_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end
            // Re-check the line at mid start bit so short glitches are dropped.
            START: begin
                if (clk_count == HALF_END) begin
                    count_nxt = '0;
                    index_nxt = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    count_nxt = clk_count + 16'd1;
                end
            end
            DATA: begin
                if (clk_count == BIT_END) begin
                    count_nxt            = '0;
                    shift_nxt[bit_index] = rx_s;
                    index_nxt            = bit_index + 3'd1;
                    if (bit_index == LAST_BIT) begin
                        index_nxt = '0;
                        state_nxt = STOP;
                    end
                end else begin
                    count_nxt = clk_count + 16'd1;
                end
            end
            STOP: begin
                if (clk_count == BIT_END) begin
                    count_nxt = '0;
                    if (rx_s) begin
                        data_nxt  = shift_reg;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = BREAK;
                    end
                end else begin
                    count_nxt = clk_count + 16'd1;
                end
            end
            // A held-low line must return high before a new start can be seen.
            BREAK: begin
                count_nxt = '0;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table vectors, corner sequences and random frames against a timing/data model.
module tb_uart_rx;

    localparam int CLK_FREQ  = 160;
    localparam int BAUD_RATE = 10;
    localparam int DATA_BITS = 8;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = CPB / 2;
    // From the negedge rx drops to the negedge the pulse is visible:
    // two synchroniser flops, one edge for IDLE to see rx_s low, half a bit, then data+stop bit times.
    localparam int LAT       = 3 + HALF + (DATA_BITS + 1) * CPB;

    typedef struct {
        bit         ferr;
        int         cyc;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         stop_len;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    int         cyc        = 0;
    int         checks     = 0;
    int         errors     = 0;
    int         obs_rd     = 0;
    int         both_cnt   = 0;
    logic [7:0] model_data = 8'h00;
    ev_t        obs_q[$];
    ev_t        exp_q[$];

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && (rx_valid || frame_err)) begin
            if (rx_valid && frame_err) both_cnt = both_cnt + 1;
            obs_q.push_back('{ferr: frame_err, cyc: cyc, data: rx_data});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Plain serialiser: shifts a 10-bit {stop, data, start} word out LSB first.
    task automatic tx_frame(input logic [9:0] bits, output int t_low);
        t_low = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            idle(CPB);
        end
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int stop_len,
                              output int t_low);
        t_low = cyc;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = d[i];
            idle(CPB);
        end
        rx = stop_ok;
        idle(stop_len);
        rx = 1'b1;
    endtask

    task automatic expect_frame(input logic [7:0] d, input bit stop_ok, input int t_low);
        if (stop_ok) begin
            model_data = d;
            exp_q.push_back('{ferr: 1'b0, cyc: t_low + LAT, data: d});
        end else begin
            exp_q.push_back('{ferr: 1'b1, cyc: t_low + LAT, data: model_data});
        end
    endtask

    task automatic check_events(input string tag);
        int n_obs;
        n_obs = obs_q.size() - obs_rd;
        chk({tag, "_pulse_count"}, n_obs, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
            ev_t o;
            ev_t e;
            o = obs_q[obs_rd + i];
            e = exp_q[i];
            chk($sformatf("%s_%0d_is_ferr", tag, i), int'(o.ferr), int'(e.ferr));
            chk($sformatf("%s_%0d_cycle", tag, i), o.cyc, e.cyc);
            chk($sformatf("%s_%0d_data", tag, i), int'(o.data), int'(e.data));
        end
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    initial begin
        int         t;
        int         t2;
        int         slen;
        int         gap;
        bit         busy_mid;
        bit         ok;
        logic [7:0] d;
        vec_t       vt[6];

        vt[0] = '{data: 8'hA5, stop_ok: 1'b1, stop_len: CPB, exp_data: 8'hA5};
        vt[1] = '{data: 8'h3C, stop_ok: 1'b1, stop_len: CPB, exp_data: 8'h3C};
        vt[2] = '{data: 8'h81, stop_ok: 1'b0, stop_len: 40,  exp_data: 8'h3C};
        vt[3] = '{data: 8'h00, stop_ok: 1'b1, stop_len: CPB, exp_data: 8'h00};
        vt[4] = '{data: 8'hFF, stop_ok: 1'b1, stop_len: CPB, exp_data: 8'hFF};
        vt[5] = '{data: 8'h6B, stop_ok: 1'b0, stop_len: 20,  exp_data: 8'hFF};

        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_rx_busy", int'(rx_busy), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        rst = 1'b0;
        idle(4);

        foreach (vt[i]) begin
            send_frame(vt[i].data, vt[i].stop_ok, vt[i].stop_len, t);
            expect_frame(vt[i].data, vt[i].stop_ok, t);
            idle(8);
            check_events($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vt[i].exp_data));
            chk($sformatf("vec%0d_busy_after", i), int'(rx_busy), 0);
        end

        // Short low glitch: enters START, rejected at mid start bit.
        t  = cyc;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(3);
        chk("glitch_busy_in_start", int'(rx_busy), 1);
        idle(20);
        check_events("glitch");
        chk("glitch_rx_data", int'(rx_data), int'(model_data));
        chk("glitch_busy_after", int'(rx_busy), 0);

        // Good 0x3C, then 0x81 whose stop bit is held low for 40 cycles.
        send_frame(8'h3C, 1'b1, CPB, t);
        expect_frame(8'h3C, 1'b1, t);
        fork
            send_frame(8'h81, 1'b0, 40, t2);
            begin
                idle(175);
                busy_mid = rx_busy;
            end
        join
        expect_frame(8'h81, 1'b0, t2);
        chk("break_busy_while_low", int'(busy_mid), 1);
        idle(6);
        check_events("break");
        chk("break_rx_data", int'(rx_data), 8'h3C);
        chk("break_busy_after", int'(rx_busy), 0);

        // Back-to-back with no idle gap.
        send_frame(8'h00, 1'b1, CPB, t);
        send_frame(8'hFF, 1'b1, CPB, t2);
        expect_frame(8'h00, 1'b1, t);
        expect_frame(8'hFF, 1'b1, t2);
        idle(8);
        if (obs_q.size() - obs_rd >= 2)
            chk("b2b_pulse_spacing", obs_q[obs_rd + 1].cyc - obs_q[obs_rd].cyc, 10 * CPB);
        check_events("b2b");
        chk("b2b_rx_data", int'(rx_data), 8'hFF);

        // Reset during data bit 4 of 0x55; the sender is reset too, so the line goes idle.
        d  = 8'h55;
        t  = cyc;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            idle(CPB);
        end
        rx = d[4];
        idle(HALF);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rx  = 1'b1;
        model_data = 8'h00;
        idle(200);
        check_events("rst_mid");
        chk("rst_mid_rx_data", int'(rx_data), 0);
        chk("rst_mid_busy", int'(rx_busy), 0);
        send_frame(8'h96, 1'b1, CPB, t);
        expect_frame(8'h96, 1'b1, t);
        idle(8);
        check_events("after_rst");
        chk("after_rst_rx_data", int'(rx_data), 8'h96);

        // Loopback of three serialised 0x3C frames.
        for (int k = 0; k < 3; k++) begin
            tx_frame({1'b1, 8'h3C, 1'b0}, t);
            expect_frame(8'h3C, 1'b1, t);
        end
        idle(8);
        check_events("loopback");
        chk("loopback_rx_data", int'(rx_data), 8'h3C);

        // Random frames, gaps and occasional stretched low stop bits.
        for (int n = 0; n < 40; n++) begin
            d    = 8'($urandom_range(0, 255));
            ok   = ($urandom_range(0, 4) != 0);
            slen = ok ? CPB : int'($urandom_range(CPB, 3 * CPB));
            gap  = ok ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 12));
            send_frame(d, ok, slen, t);
            expect_frame(d, ok, t);
            idle(gap);
        end
        idle(10);
        check_events("random");
        chk("random_rx_data", int'(rx_data), int'(model_data));
        chk("random_busy_after", int'(rx_busy), 0);

        chk("pulse_exclusive", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
